pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage MIPS pipeline. It watches the ID, EX and MEM stages and drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves three hazard sources with fixed priority:
- multi-cycle data-memory waits, with a timeout,
- taken branches,
- load-use dependencies.

It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: memory-wait freeze with
// timeout halt, branch flush, load-use bubble, plus saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        ex_memtoreg,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        ifid_flush,
  output logic        idex_en,
  output logic        idex_bubble,
  output logic        exmem_en,
  output logic        memwb_bubble,
  output logic [1:0]  state_o,
  output logic        timeout_err,
  output logic [15:0] stall_cnt,
  output logic [7:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [7:0]  flush_cnt_q, flush_cnt_d;

  logic lu, freeze, flush_evt;

  always_comb begin
    lu = ex_memtoreg && (ex_rt != 5'd0) &&
         ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
    freeze = ((state_q == RUN) && mem_req && !mem_ready) ||
             ((state_q == MEM_WAIT) && !mem_ready) ||
             (state_q == HALT);
  end

  // Control outputs in priority order: reset, freeze, branch, load-use.
  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_en      = 1'b1;
    idex_bubble  = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    flush_evt    = 1'b0;
    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_evt   = 1'b1;
    end else if (lu) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    timeout_err_d = timeout_err_q;
    stall_cnt_d   = stall_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == MAX_W8) begin
          state_d       = HALT;
          timeout_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
    // A halted pipeline is not counted as stalling.
    if (!pc_en && (state_q != HALT) && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush_evt && (flush_cnt_q != 8'hFF))
      flush_cnt_d = flush_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      wait_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      timeout_err_q <= timeout_err_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign state_o     = state_q;
  assign timeout_err = timeout_err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver predicts each cycle's outputs from a
// rule-level model and queues them; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;
  localparam int MAXW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_memtoreg, ex_branch_taken, mem_req, mem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble;
  logic [1:0]  state_o;
  logic        timeout_err;
  logic [15:0] stall_cnt;
  logic [7:0]  flush_cnt;

  pipe_hazard_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memtoreg(ex_memtoreg), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
    .state_o(state_o), .timeout_err(timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct packed {
    logic [6:0]  ctl;
    logic [1:0]  st;
    logic        to;
    logic [15:0] sc;
    logic [7:0]  fc;
  } exp_t;

  exp_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference model: mode 0=running, 1=waiting on memory, 2=halted.
  int m_mode = 0, m_wait = 0, m_to = 0, m_stall = 0, m_flush = 0;

  task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt,
                      input bit urs, input bit urt, input bit ld, input logic [4:0] lrt,
                      input bit br, input bit req, input bit rdy);
    bit pe, ie, ff, de, db, ee, mb, frz, hz;
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    ex_memtoreg = ld; ex_rt = lrt; ex_branch_taken = br; mem_req = req; mem_ready = rdy;

    e.st = 2'(m_mode); e.to = m_to[0]; e.sc = 16'(m_stall); e.fc = 8'(m_flush);
    pe = 1; ie = 1; ff = 0; de = 1; db = 0; ee = 1; mb = 0;
    frz = (m_mode == 2) || (m_mode == 1 && !rdy) || (m_mode == 0 && req && !rdy);
    hz  = ld && (lrt != 0) && ((urs && lrt == rs) || (urt && lrt == rt));
    if (r) begin
      pe = 0; ie = 0; de = 0; ee = 0; ff = 1; db = 1; mb = 1;
    end else if (frz) begin
      pe = 0; ie = 0; de = 0; ee = 0; mb = 1;
    end else if (br) begin
      ff = 1; db = 1; pe = 1;
    end else if (hz) begin
      pe = 0; ie = 0; db = 1;
    end
    e.ctl = {pe, ie, ff, de, db, ee, mb};
    exp_q.push_back(e);

    if (r) begin
      m_mode = 0; m_wait = 0; m_to = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (!pe && m_mode != 2 && m_stall < 65535) m_stall++;
      if (!frz && br && m_flush < 255) m_flush++;
      if (m_mode == 0) begin
        if (req && !rdy) begin m_mode = 1; m_wait = 1; end
      end else if (m_mode == 1) begin
        if (rdy) m_mode = 0;
        else if (m_wait == MAXW) begin m_mode = 2; m_to = 1; end
        else m_wait++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("ctl", 16'({pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_bubble}),
            16'(e.ctl));
        chk("state", 16'(state_o), 16'(e.st));
        chk("timeout_err", 16'(timeout_err), 16'(e.to));
        chk("stall_cnt", stall_cnt, e.sc);
        chk("flush_cnt", 16'(flush_cnt), 16'(e.fc));
      end
    end
  end

  initial begin
    rst = 1; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    ex_memtoreg = 0; ex_rt = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
    @(posedge clk);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // load-use on r8, then the same with r0 as destination
    step(0, 8, 3, 1, 0, 1, 8, 0, 0, 0);
    idle(2);
    step(0, 0, 0, 1, 1, 1, 0, 0, 0, 0);
    idle(2);
    // branch and load-use together
    step(0, 8, 0, 1, 0, 1, 8, 1, 0, 0);
    idle(2);
    // memory wait with a pending branch, ready on the 4th cycle
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    idle(2);
    // timeout into halt, then recover by reset
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    // randomized traffic over a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 63) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1);
    end
    // saturation
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 5, 0, 1, 0, 1, 5, 0, 0, 0);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    idle(2);
    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
